// File: rtl/counter_rate_meter.sv
// Windowed rate meter: samples a clk-domain binary counter every WINDOW cycles and
// streams the modular per-window increment with a plausibility flag, running max and overrun.
module counter_rate_meter #(
    parameter int unsigned     BITS      = 32,
    parameter int unsigned     WINDOW    = 1024,
    parameter logic [BITS-1:0] MAX_DELTA = {1'b0, {(BITS-1){1'b1}}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [BITS-1:0] counter_in,
    input  logic            max_clr,
    output logic            rate_valid,
    input  logic            rate_ready,
    output logic [BITS-1:0] rate_data,
    output logic            rate_err,
    output logic [BITS-1:0] rate_max,
    output logic            overrun
);

    localparam int unsigned  TW         = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(WINDOW - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [BITS-1:0] prev_q, prev_d;
    logic            tick_q, tick_d;
    logic [BITS-1:0] delta_q, delta_d;
    logic            derr_q, derr_d;
    logic            valid_q, valid_d;
    logic [BITS-1:0] data_q, data_d;
    logic            err_q, err_d;
    logic [BITS-1:0] max_q, max_d;
    logic            ovr_q, ovr_d;
    logic [BITS-1:0] sample_delta;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en)  state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: window timer, tick capture, then output/handshake stage
    always_comb begin
        timer_d      = timer_q;
        prev_d       = prev_q;
        tick_d       = 1'b0;
        delta_d      = delta_q;
        derr_d       = derr_q;
        valid_d      = valid_q;
        data_d       = data_q;
        err_d        = err_q;
        max_d        = max_q;
        ovr_d        = ovr_q;
        sample_delta = counter_in - prev_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    prev_d  = counter_in;
                    timer_d = '0;
                end
            end
            RUN: begin
                if (!en) begin
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    tick_d  = 1'b1;
                    delta_d = sample_delta;
                    derr_d  = (sample_delta > MAX_DELTA);
                    prev_d  = counter_in;
                    timer_d = '0;
                end else begin
                    timer_d = TW'(timer_q + 1'b1);
                end
            end
            default: timer_d = '0;
        endcase

        if (valid_q && rate_ready) valid_d = 1'b0;
        if (max_clr) begin
            max_d = '0;
            ovr_d = 1'b0;
        end
        // A captured tick loads one cycle later; it overrides any coincident clear
        if (tick_q) begin
            valid_d = 1'b1;
            data_d  = delta_q;
            err_d   = derr_q;
            if (valid_q && !rate_ready) ovr_d = 1'b1;
            if (!derr_q && (max_clr || (delta_q > max_q))) max_d = delta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            prev_q  <= '0;
            tick_q  <= 1'b0;
            delta_q <= '0;
            derr_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
            max_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            prev_q  <= prev_d;
            tick_q  <= tick_d;
            delta_q <= delta_d;
            derr_q  <= derr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            max_q   <= max_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rate_valid = valid_q;
    assign rate_data  = data_q;
    assign rate_err   = err_q;
    assign rate_max   = max_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_counter_rate_meter.sv
// Directed bench for counter_rate_meter (BITS=8, WINDOW=16, MAX_DELTA=200).
module tb_counter_rate_meter;

    localparam int unsigned BITS   = 8;
    localparam int unsigned WINDOW = 16;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [BITS-1:0] counter_in;
    logic            max_clr;
    logic            rate_valid;
    logic            rate_ready;
    logic [BITS-1:0] rate_data;
    logic            rate_err;
    logic [BITS-1:0] rate_max;
    logic            overrun;

    int checks;
    int errors;
    bit auto_inc;

    counter_rate_meter #(
        .BITS      (BITS),
        .WINDOW    (WINDOW),
        .MAX_DELTA (8'd200)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .counter_in (counter_in),
        .max_clr    (max_clr),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .rate_data  (rate_data),
        .rate_err   (rate_err),
        .rate_max   (rate_max),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_inc) counter_in = counter_in + 8'd1;
    endtask

    // Advance to the sample load edge; first=1 when starting right after a baseline capture,
    // otherwise starting one cycle after the previous load
    task automatic run_window(input bit first, input logic [BITS-1:0] target, input bit clr);
        repeat (first ? 15 : 14) step();
        counter_in = target;
        step();
        max_clr = clr;
        step();
        max_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; counter_in = '0; max_clr = 1'b0; rate_ready = 1'b1; auto_inc = 1'b0;
        repeat (2) step();
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", rate_valid); end
        checks++; if (rate_data !== 8'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", rate_data); end
        checks++; if (rate_max !== 8'd0 || overrun !== 1'b0 || rate_err !== 1'b0) begin
            errors++; $display("FAIL reset_misc got max=%0d ovr=%0b err=%0b exp 0", rate_max, overrun, rate_err); end
        #3 rst_n = 1'b1;
        repeat (3) step();
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b exp 0", rate_valid); end
    endtask

    task automatic test_steady();
        counter_in = 8'd0; rate_ready = 1'b1; auto_inc = 1'b1; en = 1'b1;
        step();
        repeat (16) step();
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL first_latency_early got valid=%0b exp 0", rate_valid); end
        step();
        checks++; if (rate_valid !== 1'b1 || rate_data !== 8'd16 || rate_err !== 1'b0) begin
            errors++; $display("FAIL first_sample got v=%0b d=%0d e=%0b exp v=1 d=16 e=0", rate_valid, rate_data, rate_err); end
        checks++; if (rate_max !== 8'd16) begin errors++; $display("FAIL first_max got %0d exp 16", rate_max); end
        step();
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL transfer_clear got %0b exp 0", rate_valid); end
        repeat (15) step();
        checks++; if (rate_valid !== 1'b1 || rate_data !== 8'd16 || rate_max !== 8'd16) begin
            errors++; $display("FAIL second_sample got v=%0b d=%0d m=%0d exp 1/16/16", rate_valid, rate_data, rate_max); end
        auto_inc = 1'b0; en = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        counter_in = 8'd250; en = 1'b1;
        step();
        run_window(1'b1, 8'd10, 1'b0);
        checks++; if (rate_valid !== 1'b1 || rate_data !== 8'd16 || rate_err !== 1'b0) begin
            errors++; $display("FAIL wrap got v=%0b d=%0d e=%0b exp 1/16/0", rate_valid, rate_data, rate_err); end
    endtask

    task automatic test_backpressure();
        step();
        rate_ready = 1'b0;
        repeat (13) step();
        counter_in = 8'd26;
        step();
        step();
        checks++; if (rate_valid !== 1'b1 || rate_data !== 8'd16 || overrun !== 1'b0) begin
            errors++; $display("FAIL bp_first got v=%0b d=%0d o=%0b exp 1/16/0", rate_valid, rate_data, overrun); end
        repeat (13) step();
        checks++; if (rate_data !== 8'd16 || rate_valid !== 1'b1) begin
            errors++; $display("FAIL bp_stable got v=%0b d=%0d exp 1/16", rate_valid, rate_data); end
        step();
        counter_in = 8'd46;
        step();
        step();
        checks++; if (rate_valid !== 1'b1 || rate_data !== 8'd20 || overrun !== 1'b1) begin
            errors++; $display("FAIL bp_overrun got v=%0b d=%0d o=%0b exp 1/20/1", rate_valid, rate_data, overrun); end
        rate_ready = 1'b1;
        step();
        checks++; if (rate_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", rate_valid); end
        max_clr = 1'b1;
        step();
        max_clr = 1'b0;
        checks++; if (overrun !== 1'b0 || rate_max !== 8'd0) begin
            errors++; $display("FAIL max_clr got o=%0b m=%0d exp 0/0", overrun, rate_max); end
    endtask

    task automatic test_jump();
        repeat (12) step();
        counter_in = 8'd62;
        step();
        step();
        checks++; if (rate_data !== 8'd16 || rate_max !== 8'd16) begin
            errors++; $display("FAIL pre_jump got d=%0d m=%0d exp 16/16", rate_data, rate_max); end
        run_window(1'b0, 8'd56, 1'b0);
        checks++; if (rate_data !== 8'd250 || rate_err !== 1'b1 || rate_max !== 8'd16) begin
            errors++; $display("FAIL jump got d=%0d e=%0b m=%0d exp 250/1/16", rate_data, rate_err, rate_max); end
        run_window(1'b0, 8'd72, 1'b0);
        checks++; if (rate_data !== 8'd16 || rate_err !== 1'b0 || rate_max !== 8'd16) begin
            errors++; $display("FAIL post_jump got d=%0d e=%0b m=%0d exp 16/0/16", rate_data, rate_err, rate_max); end
    endtask

    task automatic test_en_drop();
        rate_ready = 1'b0;
        repeat (7) step();
        en = 1'b0;
        step();
        repeat (20) step();
        checks++; if (rate_valid !== 1'b1 || rate_data !== 8'd16 || overrun !== 1'b0) begin
            errors++; $display("FAIL en_drop got v=%0b d=%0d o=%0b exp 1/16/0", rate_valid, rate_data, overrun); end
        rate_ready = 1'b1; counter_in = 8'd100; en = 1'b1;
        step();
        run_window(1'b1, 8'd116, 1'b0);
        checks++; if (rate_valid !== 1'b1 || rate_data !== 8'd16 || rate_err !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL rebaseline got v=%0b d=%0d e=%0b o=%0b exp 1/16/0/0", rate_valid, rate_data, rate_err, overrun); end
    endtask

    task automatic test_async_reset();
        repeat (3) step();
        #3 rst_n = 1'b0;
        #1;
        checks++; if (rate_valid !== 1'b0 || rate_data !== 8'd0 || rate_err !== 1'b0 || rate_max !== 8'd0 || overrun !== 1'b0) begin
            errors++; $display("FAIL async_reset got v=%0b d=%0d e=%0b m=%0d o=%0b exp all 0",
                               rate_valid, rate_data, rate_err, rate_max, overrun); end
        counter_in = 8'd40;
        #2 rst_n = 1'b1;
        step();
        run_window(1'b1, 8'd60, 1'b0);
        checks++; if (rate_valid !== 1'b1 || rate_data !== 8'd20 || rate_max !== 8'd20) begin
            errors++; $display("FAIL post_reset got v=%0b d=%0d m=%0d exp 1/20/20", rate_valid, rate_data, rate_max); end
        run_window(1'b0, 8'd72, 1'b1);
        checks++; if (rate_data !== 8'd12 || rate_max !== 8'd12) begin
            errors++; $display("FAIL clr_on_tick got d=%0d m=%0d exp 12/12", rate_data, rate_max); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_steady();
        test_wrap();
        test_backpressure();
        test_jump();
        test_en_drop();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
